// File: rtl/multi_pwm_encoder.sv
// Multi-channel PWM encoder: shared prescaler and period counter (edge- or
// center-aligned), per-channel double-buffered duty registers with atomic
// transfer at period boundaries, and registered compare outputs.
module multi_pwm_encoder #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DIV_W-1:0]          rate,
  input  logic                      center_mode,
  input  logic [CHANNELS*WIDTH-1:0] position,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_start,
  output logic                      pending
);

  localparam int unsigned DUTY_W = CHANNELS * WIDTH;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  // Prescaler state
  logic [DIV_W-1:0]    presc;
  logic                tick_c;

  // Period counter state
  logic [WIDTH-1:0]    cnt;
  logic                dir_down;
  logic [WIDTH-1:0]    cnt_next_c;
  logic                dir_next_c;
  logic                boundary_c;

  // Mode latched at period boundaries (and while idle)
  logic                mode_q;

  // Double-buffered duty storage, channel i at [i*WIDTH +: WIDTH]
  logic [DUTY_W-1:0]   shadow;
  logic [DUTY_W-1:0]   active;

  // Per-channel compare result against the current counter value
  logic [CHANNELS-1:0] duty_gt_c;

  // Tick whenever the prescaler has reached (or passed) the terminal count
  assign tick_c = enable && (presc >= rate);

  // Prescaler: free-running count while enabled, cleared on tick or when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (!enable) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end

  // Next counter value and direction for the currently latched mode
  always_comb begin
    cnt_next_c = cnt;
    dir_next_c = dir_down;
    if (mode_q) begin
      if (!dir_down) begin
        if (cnt == CNT_MAX) begin
          cnt_next_c = cnt - WIDTH'(1);
          dir_next_c = 1'b1;
        end else begin
          cnt_next_c = cnt + WIDTH'(1);
        end
      end else begin
        // Descend to 1; stepping from 1 to 0 restarts the up-count
        cnt_next_c = cnt - WIDTH'(1);
        if (cnt == CNT_ONE) begin
          dir_next_c = 1'b0;
        end
      end
    end else begin
      cnt_next_c = cnt + WIDTH'(1);
      dir_next_c = 1'b0;
    end
  end

  // A period boundary is a tick that brings the counter back to zero
  assign boundary_c = tick_c && (cnt_next_c == CNT_ZERO);

  // Period counter and direction flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (tick_c) begin
      cnt      <= cnt_next_c;
      dir_down <= dir_next_c;
    end
  end

  // Mode changes only take effect from a period boundary or while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b0;
    end else if (!enable || boundary_c) begin
      mode_q <= center_mode;
    end
  end

  // Shadow capture on load; accepted regardless of enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= position;
    end
  end

  // Atomic shadow-to-active transfer at a boundary; uses pre-load shadow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= '0;
    end else if (boundary_c && pending) begin
      active <= shadow;
    end
  end

  // Pending flag: a coincident load keeps it set for the following boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (load) begin
      pending <= 1'b1;
    end else if (boundary_c) begin
      pending <= 1'b0;
    end
  end

  // Per-channel duty comparators on the counter value currently held
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
    assign duty_gt_c[gi] = active[gi*WIDTH +: WIDTH] > cnt;
  end

  // Registered PWM outputs, forced low while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm <= '0;
    end else if (!enable) begin
      pwm <= '0;
    end else begin
      pwm <= duty_gt_c;
    end
  end

  // Boundary pulse, aligned with the cycle in which cnt reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_start <= 1'b0;
    end else begin
      period_start <= boundary_c;
    end
  end

endmodule

// File: tb/tb_multi_pwm_encoder.sv
// Scoreboard bench for multi_pwm_encoder: a phase-based reference model
// predicts pwm/period_start/pending per cycle; a monitor compares.
module tb_multi_pwm_encoder;

  localparam int W    = 10;
  localparam int CH   = 4;
  localparam int DW   = 24;
  localparam int MAXC = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [DW-1:0]   rate;
  logic            center_mode;
  logic [CH*W-1:0] position;
  logic            load;
  logic [CH-1:0]   pwm;
  logic            period_start;
  logic            pending;

  always #5 clk = ~clk;

  multi_pwm_encoder #(.WIDTH(W), .CHANNELS(CH), .DIV_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rate         (rate),
    .center_mode  (center_mode),
    .position     (position),
    .load         (load),
    .pwm          (pwm),
    .period_start (period_start),
    .pending      (pending)
  );

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          ps;
    logic          pend;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Stimulus variables applied at each negedge by step()
  bit            s_rst, s_en, s_cm, s_ld;
  int            s_rate;
  logic [CH*W-1:0] s_pos;

  // Reference model: position within the period rather than a counter
  int m_presc, m_phase;
  bit m_mode, m_pend, m_bnd;
  int m_shadow[CH];
  int m_active[CH];

  bit meas;
  int meas_hi, meas_ps;

  function automatic int period_of(bit md);
    return md ? 2 * MAXC : MAXC + 1;
  endfunction

  function automatic int cnt_of(int ph, bit md);
    return (md && ph > MAXC) ? 2 * MAXC - ph : ph;
  endfunction

  function automatic bit next_is_boundary();
    return s_rst && s_en && (m_presc >= s_rate) &&
           (((m_phase + 1) % period_of(m_mode)) == 0);
  endfunction

  task automatic capture();
    for (int i = 0; i < CH; i++) m_shadow[i] = int'(s_pos[i*W +: W]);
    m_pend = 1'b1;
  endtask

  // One clock: apply inputs, advance the model, queue the expectation
  task automatic step();
    exp_t e;
    int   c;
    bit   tk;
    @(negedge clk);
    if (meas) begin
      meas_hi += int'(pwm[0]);
      meas_ps += int'(period_start);
    end
    reset       = s_rst;
    enable      = s_en;
    center_mode = s_cm;
    load        = s_ld;
    rate        = DW'(s_rate);
    position    = s_pos;
    e     = '0;
    m_bnd = 1'b0;
    if (!s_rst) begin
      m_presc = 0;
      m_phase = 0;
      m_mode  = 1'b0;
      m_pend  = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else if (!s_en) begin
      m_presc = 0;
      m_phase = 0;
      m_mode  = s_cm;
      if (s_ld) capture();
    end else begin
      c = cnt_of(m_phase, m_mode);
      for (int i = 0; i < CH; i++) e.pwm[i] = (m_active[i] > c);
      tk      = (m_presc >= s_rate);
      m_presc = tk ? 0 : m_presc + 1;
      if (tk) begin
        m_phase = (m_phase + 1) % period_of(m_mode);
        m_bnd   = (m_phase == 0);
      end
      if (m_bnd) begin
        if (m_pend) begin
          for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
          m_pend = 1'b0;
        end
        m_mode = s_cm;
      end
      if (s_ld) capture();
      e.ps = m_bnd;
    end
    e.pend = m_pend;
    q.push_back(e);
    s_ld = 1'b0;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until the next clock edge is a period boundary (bounded)
  task automatic run_to_boundary(string tag);
    for (int k = 0; k < 40000; k++) begin
      if (next_is_boundary()) return;
      step();
    end
    tests++;
    fails++;
    $display("FAIL %s: no boundary within budget, got none, want one", tag);
  endtask

  task automatic rand_pos();
    for (int i = 0; i < CH; i++) begin
      case ($urandom_range(0, 5))
        0:       s_pos[i*W +: W] = '0;
        1:       s_pos[i*W +: W] = W'(MAXC);
        default: s_pos[i*W +: W] = W'($urandom_range(0, MAXC));
      endcase
    end
  endtask

  // Monitor: pops one expectation per clock and compares
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        tests++;
        if ({pwm, period_start, pending} !== mon_e) begin
          fails++;
          $display("FAIL scoreboard @%0t: got pwm=%b ps=%b pend=%b, want pwm=%b ps=%b pend=%b",
                   $time, pwm, period_start, pending, mon_e.pwm, mon_e.ps, mon_e.pend);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b0; center_mode = 1'b0; load = 1'b0;
    rate = '0; position = '0;
    s_rst = 1'b0; s_en = 1'b0; s_cm = 1'b0; s_ld = 1'b0; s_rate = 0; s_pos = '0;
    meas = 1'b0; meas_hi = 0; meas_ps = 0;

    // Reset, then idle
    run(3);
    s_rst = 1'b1;
    run(2);

    // Edge mode, ch0 = 256, rate 0: duty ratio and period length
    rand_pos();
    s_pos[0 +: W] = W'(256);
    s_ld = 1'b1;
    step();
    s_en = 1'b1;
    run_to_boundary("first_boundary");
    step();
    run(2);
    meas = 1'b1;
    run(2048);
    meas = 1'b0;
    tests++;
    if (meas_hi != 512) begin
      fails++;
      $display("FAIL edge_duty256: got %0d high clks in 2048, want 512", meas_hi);
    end
    tests++;
    if (meas_ps != 2) begin
      fails++;
      $display("FAIL edge_period1024: got %0d period_start in 2048, want 2", meas_ps);
    end

    // Mid-period load of ch1 = 900
    run(500);
    s_pos[W +: W] = W'(900);
    s_ld = 1'b1;
    step();
    run_to_boundary("midperiod_load");
    run(20);

    // Load coincident with boundary: old shadow transfers, new one waits
    rand_pos();
    s_ld = 1'b1;
    step();
    run_to_boundary("coincident_a");
    rand_pos();
    s_ld = 1'b1;
    step();
    run_to_boundary("coincident_b");
    run(100);

    // Center mode with ch0 = 100
    s_cm = 1'b1;
    s_pos[0 +: W] = W'(100);
    s_ld = 1'b1;
    step();
    run_to_boundary("center_switch");
    run(4200);

    // Duty extremes in edge mode
    s_cm = 1'b0;
    s_pos = '0;
    s_pos[0 +: W] = W'(MAXC);
    s_pos[3*W +: W] = W'(1);
    s_ld = 1'b1;
    step();
    run_to_boundary("extremes");
    run(1100);

    // Rate lowered from 9 to 2 while prescaler reads 5
    s_rate = 9;
    for (int k = 0; k < 40 && m_presc != 5; k++) step();
    tests++;
    if (m_presc != 5) begin
      fails++;
      $display("FAIL rate_setup: got presc %0d, want 5", m_presc);
    end
    s_rate = 2;
    run(3500);
    s_rate = 0;

    // Randomized traffic
    for (int k = 0; k < 25000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        rand_pos();
        s_ld = 1'b1;
      end
      if ($urandom_range(0, 1999) == 0) s_cm = ~s_cm;
      if ($urandom_range(0, 1499) == 0) s_rate = $urandom_range(0, 3);
      if ($urandom_range(0, 2999) == 0) begin
        s_en = 1'b0;
        run($urandom_range(1, 20));
        s_en = 1'b1;
      end
      step();
    end

    // Reset mid-period with pending data
    s_cm = 1'b0;
    s_rate = 0;
    rand_pos();
    s_ld = 1'b1;
    step();
    run(300);
    s_rst = 1'b0;
    step();
    #1;
    tests++;
    if (pwm !== '0 || pending !== 1'b0 || period_start !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got pwm=%b pend=%b ps=%b, want all 0",
               pwm, pending, period_start);
    end
    run(3);
    s_rst = 1'b1;
    run(1100);
    rand_pos();
    s_ld = 1'b1;
    step();
    run_to_boundary("post_reset");
    run(200);

    // Drain scoreboard
    @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d left in queue, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
